// File: rtl/icache_assoc_pkg.sv
// Shared definitions for the set-associative instruction cache:
// controller state encoding and address-field width helpers.
package icache_assoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MISS    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    function automatic int tag_width(input int aw, input int bw, input int iw);
        return aw - bw - iw - BYTE_OFF_W;
    endfunction

    // Zero-width fields (direct-mapped, one-word blocks) still need a 1-bit carrier.
    function automatic int at_least_one(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// Tag, valid and block storage for a single cache way: one asynchronous
// read port, one write port and a single-cycle invalidate-all.
module icache_way_array #(
    parameter int INDEX_WIDTH = 6,
    parameter int TAG_WIDTH   = 22,
    parameter int DATA_WIDTH  = 128
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   inv_i,
    input  logic                   we_i,
    input  logic [INDEX_WIDTH-1:0] widx_i,
    input  logic [TAG_WIDTH-1:0]   wtag_i,
    input  logic [DATA_WIDTH-1:0]  wdata_i,
    input  logic [INDEX_WIDTH-1:0] ridx_i,
    output logic                   valid_o,
    output logic [TAG_WIDTH-1:0]   tag_o,
    output logic [DATA_WIDTH-1:0]  data_o
);
    localparam int SETS = 1 << INDEX_WIDTH;

    logic [SETS-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    // Valid bits: the only state that reset and invalidate touch.
    always_ff @(posedge clk_i) begin
        if (rst_i || inv_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[widx_i] <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Tag and data payload, written on refill only.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[widx_i]  <= wtag_i;
            data_q[widx_i] <= wdata_i;
        end
    end

    assign valid_o = valid_q[ridx_i];
    assign tag_o   = tag_q[ridx_i];
    assign data_o  = data_q[ridx_i];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin replacement per set,
// miss refill, mispredict discard and fence.i invalidate-all.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WIDTH = 2,
    parameter int INDEX_WIDTH = 6,
    parameter int WAY_WIDTH   = 1
) (
    input  logic                             Sys_clk,
    input  logic                             Sys_rst,
    input  logic                             Sys_rdy,
    input  logic                             IFIC_en,
    input  logic [ADDR_WIDTH-1:0]            IFIC_addr,
    output logic                             ICIF_en,
    output logic [31:0]                      ICIF_data,
    output logic                             ICMC_en,
    output logic [ADDR_WIDTH-1:0]            ICMC_addr,
    input  logic                             MCIC_en,
    input  logic [32*(1<<BLOCK_WIDTH)-1:0]   MCIC_block,
    input  logic                             RoBIC_pre_judge,
    input  logic                             ICIF_inv
);
    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
    localparam int WAYS       = 1 << WAY_WIDTH;
    localparam int SETS       = 1 << INDEX_WIDTH;
    localparam int BLK_BITS   = WORD_W * BLOCK_SIZE;
    localparam int LOW_BITS   = BLOCK_WIDTH + BYTE_OFF_W;
    localparam int TAG_W      = tag_width(ADDR_WIDTH, BLOCK_WIDTH, INDEX_WIDTH);
    localparam int OFF_W      = at_least_one(BLOCK_WIDTH);
    localparam int RRW        = at_least_one(WAY_WIDTH);
    localparam logic [OFF_W-1:0] OFF_MASK = OFF_W'(BLOCK_SIZE - 1);

    function automatic logic [OFF_W-1:0] f_off(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] s;
        s = a >> BYTE_OFF_W;
        return s[OFF_W-1:0] & OFF_MASK;
    endfunction

    function automatic logic [INDEX_WIDTH-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] s;
        s = a >> LOW_BITS;
        return s[INDEX_WIDTH-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] f_tag(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] s;
        s = a >> (LOW_BITS + INDEX_WIDTH);
        return s[TAG_W-1:0];
    endfunction

    function automatic logic [31:0] f_word(input logic [BLK_BITS-1:0] blk,
                                           input logic [OFF_W-1:0] off);
        logic [BLK_BITS-1:0] s;
        s = blk >> {off, 5'b00000};
        return s[31:0];
    endfunction

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   miss_addr_q;
    logic                    no_fill_q;
    logic [RRW-1:0]          rr_q [SETS];

    logic [INDEX_WIDTH-1:0]  req_idx_s, fill_idx_s;
    logic [TAG_W-1:0]        req_tag_s, fill_tag_s;
    logic [OFF_W-1:0]        req_off_s;
    logic                    fill_ev_s, fill_we_s, hit_s;
    logic [BLK_BITS-1:0]     hit_blk_s;
    logic [RRW-1:0]          rr_next_d;
    logic                    way_valid_s [WAYS];
    logic [TAG_W-1:0]        way_tag_s   [WAYS];
    logic [BLK_BITS-1:0]     way_data_s  [WAYS];
    logic [WAYS-1:0]         way_we_s;

    assign req_idx_s  = f_idx(IFIC_addr);
    assign req_tag_s  = f_tag(IFIC_addr);
    assign req_off_s  = f_off(IFIC_addr);
    assign fill_idx_s = f_idx(miss_addr_q);
    assign fill_tag_s = f_tag(miss_addr_q);

    // A pending refill completes in any non-idle state; a mispredict does not stall it.
    assign fill_ev_s = MCIC_en && (state_q != ST_IDLE) && (Sys_rdy || !RoBIC_pre_judge);
    assign fill_we_s = fill_ev_s && !no_fill_q && !ICIF_inv && !Sys_rst;
    assign rr_next_d = RRW'((int'(rr_q[fill_idx_s]) + 1) % WAYS);

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            assign way_we_s[w] = fill_we_s && (rr_q[fill_idx_s] == RRW'(w));
            icache_way_array #(
                .INDEX_WIDTH (INDEX_WIDTH),
                .TAG_WIDTH   (TAG_W),
                .DATA_WIDTH  (BLK_BITS)
            ) u_way (
                .clk_i   (Sys_clk),
                .rst_i   (Sys_rst),
                .inv_i   (ICIF_inv),
                .we_i    (way_we_s[w]),
                .widx_i  (fill_idx_s),
                .wtag_i  (fill_tag_s),
                .wdata_i (MCIC_block),
                .ridx_i  (req_idx_s),
                .valid_o (way_valid_s[w]),
                .tag_o   (way_tag_s[w]),
                .data_o  (way_data_s[w])
            );
        end
    endgenerate

    // Hit select: tags are unique within a set, so OR-merging matching ways is safe.
    always_comb begin
        hit_s     = 1'b0;
        hit_blk_s = '0;
        for (int i = 0; i < WAYS; i++) begin
            hit_s     = hit_s | (way_valid_s[i] && (way_tag_s[i] == req_tag_s));
            hit_blk_s = hit_blk_s |
                        (way_data_s[i] & {BLK_BITS{way_valid_s[i] && (way_tag_s[i] == req_tag_s)}});
        end
    end

    // Round-robin victim pointer per set, advanced on every committed refill.
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (fill_we_s) begin
            rr_q[fill_idx_s] <= rr_next_d;
        end
    end

    // Controller FSM and registered interface outputs.
    always_ff @(posedge Sys_clk) begin
        if (Sys_rst) begin
            state_q     <= ST_IDLE;
            miss_addr_q <= '0;
            no_fill_q   <= 1'b0;
            ICIF_en     <= 1'b0;
            ICIF_data   <= 32'h0000_0000;
            ICMC_en     <= 1'b0;
            ICMC_addr   <= '0;
        end else if (ICIF_inv) begin
            ICIF_en <= 1'b0;
            ICMC_en <= 1'b0;
            if (state_q == ST_IDLE) begin
                state_q <= ST_IDLE;
            end else if (MCIC_en) begin
                state_q   <= ST_IDLE;
                no_fill_q <= 1'b0;
            end else begin
                state_q   <= ST_DISCARD;
                no_fill_q <= 1'b1;
            end
        end else if (!RoBIC_pre_judge) begin
            ICIF_en <= 1'b0;
            ICMC_en <= 1'b0;
            if (fill_ev_s) begin
                state_q   <= ST_IDLE;
                no_fill_q <= 1'b0;
            end else if (state_q == ST_MISS) begin
                state_q <= ST_DISCARD;
            end else begin
                state_q <= state_q;
            end
        end else if (!Sys_rdy) begin
            state_q <= state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The pulse cycle never re-accepts, so a held request is not served twice.
                    if (IFIC_en && !ICIF_en) begin
                        if (hit_s) begin
                            ICIF_en   <= 1'b1;
                            ICIF_data <= f_word(hit_blk_s, req_off_s);
                        end else begin
                            ICIF_en     <= 1'b0;
                            miss_addr_q <= IFIC_addr;
                            ICMC_en     <= 1'b1;
                            ICMC_addr   <= (IFIC_addr >> LOW_BITS) << LOW_BITS;
                            state_q     <= ST_MISS;
                        end
                    end else begin
                        ICIF_en <= 1'b0;
                    end
                end
                ST_MISS: begin
                    if (MCIC_en) begin
                        ICIF_en   <= 1'b1;
                        ICIF_data <= f_word(MCIC_block, f_off(miss_addr_q));
                        ICMC_en   <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        ICMC_en <= 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (MCIC_en) begin
                        state_q   <= ST_IDLE;
                        no_fill_q <= 1'b0;
                    end else begin
                        state_q <= ST_DISCARD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ICIF_en <= 1'b0;
                    ICMC_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (default parameters: 4-word blocks, 64 sets, 2 ways).
module tb_icache_assoc;

    logic         clk = 1'b0;
    logic         Sys_rst, Sys_rdy, IFIC_en, MCIC_en, RoBIC_pre_judge, ICIF_inv;
    logic [31:0]  IFIC_addr, ICIF_data, ICMC_addr;
    logic         ICIF_en, ICMC_en;
    logic [127:0] MCIC_block;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] exp_q [$];

    // Reference model: 64 sets x 2 ways of {valid, tag}, one victim pointer per set.
    bit          m_valid [64][2];
    int unsigned m_tag   [64][2];
    int          m_rr    [64];

    always #5 clk = ~clk;

    icache_assoc dut (
        .Sys_clk         (clk),
        .Sys_rst         (Sys_rst),
        .Sys_rdy         (Sys_rdy),
        .IFIC_en         (IFIC_en),
        .IFIC_addr       (IFIC_addr),
        .ICIF_en         (ICIF_en),
        .ICIF_data       (ICIF_data),
        .ICMC_en         (ICMC_en),
        .ICMC_addr       (ICMC_addr),
        .MCIC_en         (MCIC_en),
        .MCIC_block      (MCIC_block),
        .RoBIC_pre_judge (RoBIC_pre_judge),
        .ICIF_inv        (ICIF_inv)
    );

    // Backing memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (wa == 32'h0000_1004) return 32'hDEADBEEF;
        return ((wa ^ 32'h5A5A_0000) * 32'h9E37_79B1) + 32'h0000_1234;
    endfunction

    function automatic logic [127:0] mem_block(input logic [31:0] a);
        logic [127:0] b;
        logic [31:0]  base;
        base = a & 32'hFFFF_FFF0;
        for (int k = 0; k < 4; k++) b[32*k +: 32] = mem_word(base + 32'(4 * k));
        return b;
    endfunction

    function automatic int m_set(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd64);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] a);
        return a / 32'd1024;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        bit h = 1'b0;
        for (int wy = 0; wy < 2; wy++)
            if (m_valid[m_set(a)][wy] && m_tag[m_set(a)][wy] == m_tagof(a)) h = 1'b1;
        return h;
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int s;
        s = m_set(a);
        m_valid[s][m_rr[s]] = 1'b1;
        m_tag[s][m_rr[s]]   = m_tagof(a);
        m_rr[s]             = (m_rr[s] + 1) % 2;
    endfunction

    function automatic void m_inv_all();
        for (int s = 0; s < 64; s++) begin
            m_valid[s][0] = 1'b0;
            m_valid[s][1] = 1'b0;
        end
    endfunction

    function automatic void m_reset();
        m_inv_all();
        for (int s = 0; s < 64; s++) m_rr[s] = 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Monitor: each accepted response (IF samples only while Sys_rdy) pops one expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!Sys_rst && Sys_rdy && ICIF_en) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_resp: got ICIF_en with data 0x%08h, expected no response at %0t",
                         ICIF_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", ICIF_data, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch with memory-controller emulation; hit/miss decided by the model.
    task automatic fetch(input logic [31:0] a);
        bit exp_hit;
        exp_hit = m_hit(a);
        exp_q.push_back(mem_word(a));
        IFIC_en   = 1'b1;
        IFIC_addr = a;
        tick();
        chk("hit_or_miss", {30'd0, ICIF_en, ICMC_en}, exp_hit ? 32'd2 : 32'd1);
        if (ICIF_en) begin
            IFIC_en = 1'b0;
        end else if (ICMC_en) begin
            chk("refill_addr", ICMC_addr, a & 32'hFFFF_FFF0);
            repeat ($urandom_range(0, 3)) tick();
            chk("refill_held", {31'd0, ICMC_en}, 32'd1);
            MCIC_en    = 1'b1;
            MCIC_block = mem_block(a);
            tick();
            MCIC_en = 1'b0;
            chk("refill_resp", {31'd0, ICIF_en}, 32'd1);
            chk("refill_drop", {31'd0, ICMC_en}, 32'd0);
            IFIC_en = 1'b0;
            m_fill(a);
        end else begin
            n_total++;
            $display("FAIL no_response: got neither ICIF_en nor ICMC_en for 0x%08h, expected one", a);
            void'(exp_q.pop_back());
            IFIC_en = 1'b0;
        end
        tick();
        chk("pulse_width", {31'd0, ICIF_en}, 32'd0);
    endtask

    // Miss abandoned by a misprediction (or a fence.i when inv=1).
    task automatic abandon_miss(input logic [31:0] a, input bit inv);
        IFIC_en   = 1'b1;
        IFIC_addr = a;
        tick();
        chk("abandon_miss", {31'd0, ICMC_en}, 32'd1);
        IFIC_en = 1'b0;
        if (inv) ICIF_inv = 1'b1;
        else     RoBIC_pre_judge = 1'b0;
        tick();
        ICIF_inv        = 1'b0;
        RoBIC_pre_judge = 1'b1;
        chk("abandon_icmc_drop", {31'd0, ICMC_en}, 32'd0);
        if (inv) m_inv_all();
        tick();
        MCIC_en    = 1'b1;
        MCIC_block = mem_block(a);
        tick();
        MCIC_en = 1'b0;
        chk("abandon_no_resp", {31'd0, ICIF_en}, 32'd0);
        if (!inv) m_fill(a);
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected finish within 500us");
        $fatal(1);
    end

    initial begin
        Sys_rst = 1'b1; Sys_rdy = 1'b1; IFIC_en = 1'b0; IFIC_addr = 32'h0;
        MCIC_en = 1'b0; MCIC_block = 128'h0; RoBIC_pre_judge = 1'b1; ICIF_inv = 1'b0;
        m_reset();
        repeat (2) tick();
        chk("rst_icif_en", {31'd0, ICIF_en}, 32'd0);
        chk("rst_icmc_en", {31'd0, ICMC_en}, 32'd0);
        chk("rst_icif_data", ICIF_data, 32'h0);
        chk("rst_icmc_addr", ICMC_addr, 32'h0);
        Sys_rst = 1'b0;
        tick();

        // Cold miss then hit in the same block; then a three-way set conflict.
        chk("deadbeef_model", mem_word(32'h0000_1004), 32'hDEADBEEF);
        fetch(32'h0000_1004);
        fetch(32'h0000_1008);
        fetch(32'h0000_1400);
        fetch(32'h0000_1800);
        fetch(32'h0000_1400);
        fetch(32'h0000_1000);

        // Mispredict: discarded fill still lands in the cache.
        abandon_miss(32'h0000_2000, 1'b0);
        fetch(32'h0000_2000);

        // Stall between accept and response: exactly one response, data held.
        exp_q.push_back(mem_word(32'h0000_2004));
        IFIC_en = 1'b1; IFIC_addr = 32'h0000_2004;
        tick();
        chk("stall_accept", {31'd0, ICIF_en}, 32'd1);
        Sys_rdy = 1'b0;
        repeat (5) tick();
        chk("stall_en_held", {31'd0, ICIF_en}, 32'd1);
        chk("stall_data_held", ICIF_data, mem_word(32'h0000_2004));
        Sys_rdy = 1'b1;
        IFIC_en = 1'b0;
        tick();
        chk("stall_release", {31'd0, ICIF_en}, 32'd0);

        // Invalidate during a miss: pending fill dropped, everything misses.
        abandon_miss(32'h0000_3000, 1'b1);
        fetch(32'h0000_1000);
        fetch(32'h0000_3000);

        // Reset mid-miss followed by a stray refill pulse.
        IFIC_en = 1'b1; IFIC_addr = 32'h0000_4000;
        tick();
        chk("rstmiss_icmc", {31'd0, ICMC_en}, 32'd1);
        IFIC_en = 1'b0;
        Sys_rst = 1'b1;
        tick();
        Sys_rst = 1'b0;
        m_reset();
        chk("rstmiss_icmc_drop", {31'd0, ICMC_en}, 32'd0);
        MCIC_en = 1'b1; MCIC_block = mem_block(32'h0000_4000);
        tick();
        MCIC_en = 1'b0;
        chk("stray_mcic", {31'd0, ICIF_en}, 32'd0);
        tick();
        fetch(32'h0000_1000);
        fetch(32'h0000_3000);

        // Random fetches over 5 tags x 4 sets to exercise hits and evictions.
        for (int i = 0; i < 80; i++) begin
            fetch((32'($urandom_range(0, 4)) << 12) | (32'($urandom_range(0, 3)) << 4) |
                  (32'($urandom_range(0, 3)) << 2));
        end

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised set-associative instruction cache between the instruction fetcher and the memory controller.
- Successor to the direct-mapped, fixed 2-word-block cache. Generalises block size, set count and associativity, with round-robin replacement per set.
- Adds a latched miss address, refill-on-discard and whole-cache invalidation for fence.i.

Parameters:
ADDR_WIDTH, 32, address bits
BLOCK_WIDTH, 2, log2(instructions per block); BLOCK_SIZE = 1<<BLOCK_WIDTH, any value 0..4
INDEX_WIDTH, 6, log2(sets)
WAY_WIDTH, 1, log2(ways); WAYS = 1<<WAY_WIDTH, 0 gives direct-mapped

Ports:
Sys_clk  in  1  clock
Sys_rst  in  1  synchronous active-high reset
Sys_rdy  in  1  global enable; low freezes all state
IFIC_en  in  1  fetch request, level, held by IF until ICIF_en
IFIC_addr  in  ADDR_WIDTH  fetch address, [1:0]=00
ICIF_en  out  1  one-cycle response pulse
ICIF_data  out  32  instruction
ICMC_en  out  1  refill request, held until MCIC_en
ICMC_addr  out  ADDR_WIDTH  block-aligned refill address
MCIC_en  in  1  one-cycle refill-done pulse
MCIC_block  in  32*BLOCK_SIZE  refill data, word k at [32k+31:32k]
RoBIC_pre_judge  in  1  low = misprediction, abandon current fetch
ICIF_inv  in  1  one-cycle pulse, invalidate all lines

Behaviour:
- One clock, Sys_clk. Reset Sys_rst is synchronous, active-high.
- Address split: offset=[BLOCK_WIDTH+1:2], index=[BLOCK_WIDTH+INDEX_WIDTH+1:BLOCK_WIDTH+2], tag=the rest.
- Reset: all valid bits 0, all round-robin pointers 0, state IDLE, ICIF_en=0, ICMC_en=0, ICIF_data=0, ICMC_addr=0.
- Priority each cycle: Sys_rst > ICIF_inv > RoBIC_pre_judge==0 > Sys_rdy==0 (hold everything) > normal operation.
- States: IDLE, MISS, DISCARD.
- IDLE, request accepted when IFIC_en=1 and ICIF_en=0:
  - Hit (any way valid with matching tag): next cycle ICIF_en=1, ICIF_data = hit word. Hit latency 1.
  - ICIF_en is forced low the following cycle. A held request is not re-accepted in the pulse cycle, so back-to-back hits issue every 2 cycles.
  - Miss: latch miss_addr=IFIC_addr. Next cycle ICMC_en=1, ICMC_addr=IFIC_addr with low BLOCK_WIDTH+2 bits cleared. Go MISS.
- MISS: ICMC_en held 1. IFIC_en/IFIC_addr are ignored.
  - On MCIC_en: write the block into way rr[index of miss_addr], set valid, write tag, advance rr (mod WAYS).
  - Same edge: ICIF_en=1, ICIF_data = word at latched miss offset; ICMC_en=0; go IDLE.
  - Refill-to-response latency is 1 cycle after MCIC_en.
- RoBIC_pre_judge==0:
  - ICIF_en=0 and ICMC_en=0 next cycle.
  - IDLE stays IDLE.
  - MISS goes to DISCARD; miss_addr is kept.
- DISCARD: wait for MCIC_en. The fill is still written to the cache using miss_addr. No ICIF_en. Go IDLE. Fetch requests are ignored until then.
- ICIF_inv: all valid bits cleared in one cycle; rr pointers unchanged.
  - In MISS or DISCARD: go DISCARD and set no_fill, so the pending block is dropped, not written.
  - no_fill clears on that MCIC_en.
  - An ICIF_inv coinciding with MCIC_en wins: no write, no response.
- Simultaneous hit request and MCIC_en in IDLE cannot occur; the memory controller only pulses MCIC_en after ICMC_en.
- Sys_rdy low: no state, array or output changes. The memory controller is also frozen, so no MCIC_en is lost.
- Reset mid-MISS: returns to IDLE. A later stray MCIC_en in IDLE is ignored.

Decomposition:
- Shared package: state encoding (IDLE/MISS/DISCARD), address-field slice widths as localparams derived from the parameters.
- One sub-module, icache_way_array: tag/valid/data storage for one way with invalidate-all and a single write port.
- The top instantiates WAYS copies via generate, plus hit-select, rr pointers and the FSM.

Test Plan:
- Cold miss: fetch 0x0000_1004 (BLOCK_WIDTH=2) -> ICMC_addr=0x0000_1000. MCIC_block word1=0xDEADBEEF -> ICIF_en pulse with 0xDEADBEEF. Refetch 0x1008 hits in 1 cycle.
- Conflict: with WAYS=2, INDEX_WIDTH=6, fill 0x1000, 0x1400, 0x1800 (same set) -> third evicts 0x1000. Refetch 0x1400 hits; refetch 0x1000 misses.
- Mispredict: RoBIC_pre_judge low in MISS for 0x2000 -> ICMC_en drops, no ICIF_en on MCIC_en. Later fetch of 0x2000 hits (discarded fill written).
- Invalidate: ICIF_inv during MISS for 0x3000 -> fill not written. Fetch 0x1000 (previously cached) misses.
- Stall: Sys_rdy low for 5 cycles between hit accept and response -> ICIF_en asserted exactly once, data unchanged.
- Reset: Sys_rst during MISS, then stray MCIC_en -> no ICIF_en. All prior lines miss.
